layer_dispatch_sched: RTL
=========================

Name: layer_dispatch_sched

Overview:
Per-layer scheduler between the PS config path and the three compute engines (LSTM, FC, CNN). It assembles 128-bit config beats into one 512-bit layer descriptor and decodes the layer type. It then configures and starts the matching engine, waits for that engine's done, and repeats until a descriptor flagged "last" completes. It drives the engine-select controls (SPMV_sel, mode_sel, fc_relu_en) for the whole layer.

Parameters:
- BEAT_W, 128, width of one config beat.
- BEATS, 4, beats per layer descriptor; descriptor width is BEAT_W*BEATS = 512.
- CNT_W, 8, width of the layer counter.
- WDT_CYC, 1048576, watchdog limit in WAIT (used only with LAYER_WDT_EN).

Ports:
- ddr_user_clk  in  1  clock
- ddr_user_rst  in  1  reset, asynchronous, active-high
- I_cfg_value  in  128  config beat
- I_cfg_valid  in  1  beat valid
- O_cfg_ready  out  1  beat accepted when I_cfg_valid & O_cfg_ready
- I_err_clr  in  1  clears the error state
- I_LSTM_cal_done / I_FC_cal_done / I_CNN_cal_done  in  1 each  engine done pulses
- O_LSTM_cfg_value / O_FC_cfg_value / O_CNN_cfg_value  out  512 each  descriptor to the engine
- O_LSTM_cfg_valid / O_FC_cfg_valid / O_CNN_cfg_valid  out  1 each  1-cycle config strobe
- O_LSTM_cal_start / O_FC_cal_start / O_CNN_cal_start  out  1 each  1-cycle start strobe
- O_SPMV_sel  out  1  0 = LSTM/FC, 1 = CNN
- O_mode_sel  out  1  0 = LSTM, 1 = FC
- O_fc_relu_en  out  1  ReLU enable for FC
- O_busy  out  1  high outside IDLE and ERR
- O_task_done  out  1  1-cycle pulse after the last layer completes
- O_layer_cnt  out  CNT_W  layers completed in the current task
- O_err  out  1  sticky error flag
- O_err_code  out  2  01 = reserved type, 10 = watchdog

Behaviour:
- Reset: all outputs 0, except O_cfg_ready = 1. State is IDLE, beat counter 0, descriptor register 0.
- Beat assembly: beat k is written to descriptor bits [128k+127:128k], k = 0..3. The beat counter wraps to 0 after beat 3.
- Descriptor fields:
  - type = desc[1:0]: 00 LSTM, 01 FC, 10 CNN, 11 reserved.
  - last = desc[2].
- States:
  - IDLE: ready = 1. The first accepted beat clears O_layer_cnt to 0 and moves to COLLECT.
  - COLLECT: ready = 1. When the 4th beat is accepted, ready drops to 0 on the next cycle; go to DECODE.
  - DECODE (1 cycle):
    - Type 11: go to ERR with code 01.
    - Otherwise register the mode outputs:
      - SPMV_sel = (type == 10).
      - mode_sel = (type == 01).
      - fc_relu_en = (type == 01) & ~last.
    - Go to CFG.
  - CFG (1 cycle): the selected O_*_cfg_valid = 1. The selected O_*_cfg_value has held the descriptor since DECODE and holds it until the next DECODE. Go to START.
  - START (1 cycle): the selected O_*_cal_start = 1. Go to WAIT.
  - WAIT:
    - Only the selected engine's done is honoured. Done pulses from other engines are ignored. Done pulses arriving in any state other than WAIT are ignored.
    - On done: O_layer_cnt += 1, saturating at 2^CNT_W − 1.
    - Then: if last, go to DONE; otherwise go to COLLECT with ready = 1.
  - DONE (1 cycle): O_task_done = 1, then go to IDLE. Mode outputs and O_layer_cnt hold.
  - ERR:
    - O_err = 1, ready = 0, all strobes 0.
    - I_err_clr returns to IDLE and clears O_err, O_err_code, the beat counter and the mode outputs.
- Latency: 4th beat accepted in cycle t → cfg_valid at t+2 → cal_start at t+3 → done sampled from t+4.
- Beats are never accepted outside IDLE/COLLECT. A sender holding I_cfg_valid during WAIT stalls; no beat is lost.
- Reset asserted mid-operation: immediate return to the reset values. An engine already started is not aborted; its later done is ignored because the block is in IDLE.

Optional Feature:
Macro LAYER_WDT_EN.
- Defined: a cycle counter runs in WAIT and clears on entering WAIT. If it reaches WDT_CYC without the selected done, go to ERR with O_err_code = 10.
- Undefined: no counter; WAIT waits indefinitely and O_err_code = 10 never occurs.

Test Plan:
- Single FC layer, last = 1 (desc[2:0] = 3'b101): beats 0..3 → FC_cfg_valid at t+2, FC_cal_start at t+3, mode_sel = 1, SPMV_sel = 0, fc_relu_en = 0. FC done pulse → task_done 1 cycle later, layer_cnt = 1.
- Three-layer task LSTM → FC (last = 0) → CNN (last = 1): FC phase has fc_relu_en = 1. CNN phase has SPMV_sel = 1. Exactly one task_done; layer_cnt = 3.
- Wrong-engine done: CNN layer in WAIT, LSTM done pulse → no transition. CNN done → advances.
- Reserved type 2'b11 → no cal_start, O_err = 1, err_code = 01, ready = 0. I_err_clr → IDLE, ready = 1.
- Back-pressure: I_cfg_valid held high through WAIT → ready = 0. Next descriptor's beat 0 is accepted only on the cycle after done; descriptor bits are intact.
- With LAYER_WDT_EN and WDT_CYC = 16: no done → ERR with err_code = 10 at 16 cycles after entering WAIT. Reset mid-WAIT → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/layer_dispatch_sched_if.sv
// Config-beat and engine-control bundle for layer_dispatch_sched.
// The slave modport is the scheduler side; the master modport is the PS/engine side.
interface layer_dispatch_sched_if #(
    parameter int BEAT_W = 128,
    parameter int BEATS  = 4,
    parameter int CNT_W  = 8
);
    localparam int DESC_W = BEAT_W * BEATS;

    logic [BEAT_W-1:0] I_cfg_value;
    logic              I_cfg_valid;
    logic              O_cfg_ready;
    logic              I_err_clr;
    logic              I_LSTM_cal_done;
    logic              I_FC_cal_done;
    logic              I_CNN_cal_done;
    logic [DESC_W-1:0] O_LSTM_cfg_value;
    logic [DESC_W-1:0] O_FC_cfg_value;
    logic [DESC_W-1:0] O_CNN_cfg_value;
    logic              O_LSTM_cfg_valid;
    logic              O_FC_cfg_valid;
    logic              O_CNN_cfg_valid;
    logic              O_LSTM_cal_start;
    logic              O_FC_cal_start;
    logic              O_CNN_cal_start;
    logic              O_SPMV_sel;
    logic              O_mode_sel;
    logic              O_fc_relu_en;
    logic              O_busy;
    logic              O_task_done;
    logic [CNT_W-1:0]  O_layer_cnt;
    logic              O_err;
    logic [1:0]        O_err_code;

    modport slave (
        input  I_cfg_value, I_cfg_valid, I_err_clr,
        input  I_LSTM_cal_done, I_FC_cal_done, I_CNN_cal_done,
        output O_cfg_ready,
        output O_LSTM_cfg_value, O_FC_cfg_value, O_CNN_cfg_value,
        output O_LSTM_cfg_valid, O_FC_cfg_valid, O_CNN_cfg_valid,
        output O_LSTM_cal_start, O_FC_cal_start, O_CNN_cal_start,
        output O_SPMV_sel, O_mode_sel, O_fc_relu_en,
        output O_busy, O_task_done, O_layer_cnt, O_err, O_err_code
    );

    modport master (
        output I_cfg_value, I_cfg_valid, I_err_clr,
        output I_LSTM_cal_done, I_FC_cal_done, I_CNN_cal_done,
        input  O_cfg_ready,
        input  O_LSTM_cfg_value, O_FC_cfg_value, O_CNN_cfg_value,
        input  O_LSTM_cfg_valid, O_FC_cfg_valid, O_CNN_cfg_valid,
        input  O_LSTM_cal_start, O_FC_cal_start, O_CNN_cal_start,
        input  O_SPMV_sel, O_mode_sel, O_fc_relu_en,
        input  O_busy, O_task_done, O_layer_cnt, O_err, O_err_code
    );
endinterface

// File: rtl/layer_dispatch_sched.sv
// Per-layer scheduler: assembles config beats into descriptors and runs LSTM/FC/CNN engines.
// Optional macro LAYER_WDT_EN adds a WAIT-state watchdog of WDT_CYC cycles (error code 10).
module layer_dispatch_sched #(
    parameter int BEAT_W  = 128,
    parameter int BEATS   = 4,
    parameter int CNT_W   = 8,
    parameter int WDT_CYC = 1048576
) (
    input  logic                 ddr_user_clk,
    input  logic                 ddr_user_rst,
    layer_dispatch_sched_if.slave bus
);
    localparam int DESC_W = BEAT_W * BEATS;
    localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_DECODE, S_CFG, S_START, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DESC_W-1:0] desc_q, desc_d;
    logic [DESC_W-1:0] eng_desc_q, eng_desc_d;
    logic [1:0]        sel_q, sel_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  layer_cnt_q, layer_cnt_d;
    logic              spmv_q, spmv_d, mode_q, mode_d, relu_q, relu_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              ready, accept, sel_done, wdt_hit;

    always_ff @(posedge ddr_user_clk or posedge ddr_user_rst) begin
        if (ddr_user_rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            desc_q      <= '0;
            eng_desc_q  <= '0;
            sel_q       <= '0;
            last_q      <= 1'b0;
            layer_cnt_q <= '0;
            spmv_q      <= 1'b0;
            mode_q      <= 1'b0;
            relu_q      <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            desc_q      <= desc_d;
            eng_desc_q  <= eng_desc_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            layer_cnt_q <= layer_cnt_d;
            spmv_q      <= spmv_d;
            mode_q      <= mode_d;
            relu_q      <= relu_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef LAYER_WDT_EN
    localparam int WDT_W = (WDT_CYC > 1) ? $clog2(WDT_CYC) : 1;
    logic [WDT_W-1:0] wdt_q;

    // Counter is held at zero outside WAIT, so it starts fresh on every WAIT entry.
    always_ff @(posedge ddr_user_clk or posedge ddr_user_rst) begin
        if (ddr_user_rst)
            wdt_q <= '0;
        else if (state_q != S_WAIT)
            wdt_q <= '0;
        else
            wdt_q <= wdt_q + WDT_W'(1);
    end

    assign wdt_hit = (wdt_q == WDT_W'(WDT_CYC - 1));
`else
    assign wdt_hit = 1'b0;
`endif

    always_comb begin
        case (sel_q)
            2'b00:   sel_done = bus.I_LSTM_cal_done;
            2'b01:   sel_done = bus.I_FC_cal_done;
            2'b10:   sel_done = bus.I_CNN_cal_done;
            default: sel_done = 1'b0;
        endcase
    end

    assign ready  = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign accept = ready && bus.I_cfg_valid;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        desc_d      = desc_q;
        eng_desc_d  = eng_desc_q;
        sel_d       = sel_q;
        last_d      = last_q;
        layer_cnt_d = layer_cnt_q;
        spmv_d      = spmv_q;
        mode_d      = mode_q;
        relu_d      = relu_q;
        err_code_d  = err_code_q;

        if (accept) begin
            desc_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = bus.I_cfg_value;
            beat_cnt_d = (beat_cnt_q == BC_W'(BEATS - 1)) ? '0 : beat_cnt_q + BC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    layer_cnt_d = '0;
                    state_d     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept && beat_cnt_q == BC_W'(BEATS - 1))
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (desc_q[1:0] == 2'b11) begin
                    err_code_d = 2'b01;
                    state_d    = S_ERR;
                end else begin
                    eng_desc_d = desc_q;
                    sel_d      = desc_q[1:0];
                    last_d     = desc_q[2];
                    spmv_d     = (desc_q[1:0] == 2'b10);
                    mode_d     = (desc_q[1:0] == 2'b01);
                    relu_d     = (desc_q[1:0] == 2'b01) && !desc_q[2];
                    state_d    = S_CFG;
                end
            end
            S_CFG:   state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (sel_done) begin
                    if (layer_cnt_q != '1)
                        layer_cnt_d = layer_cnt_q + CNT_W'(1);
                    state_d = last_q ? S_DONE : S_COLLECT;
                end else if (wdt_hit) begin
                    err_code_d = 2'b10;
                    state_d    = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR: begin
                if (bus.I_err_clr) begin
                    err_code_d = '0;
                    beat_cnt_d = '0;
                    spmv_d     = 1'b0;
                    mode_d     = 1'b0;
                    relu_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One descriptor register feeds all engines; only the selected engine is strobed.
    always_comb begin
        bus.O_cfg_ready      = ready;
        bus.O_LSTM_cfg_value = eng_desc_q;
        bus.O_FC_cfg_value   = eng_desc_q;
        bus.O_CNN_cfg_value  = eng_desc_q;
        bus.O_LSTM_cfg_valid = (state_q == S_CFG)   && (sel_q == 2'b00);
        bus.O_FC_cfg_valid   = (state_q == S_CFG)   && (sel_q == 2'b01);
        bus.O_CNN_cfg_valid  = (state_q == S_CFG)   && (sel_q == 2'b10);
        bus.O_LSTM_cal_start = (state_q == S_START) && (sel_q == 2'b00);
        bus.O_FC_cal_start   = (state_q == S_START) && (sel_q == 2'b01);
        bus.O_CNN_cal_start  = (state_q == S_START) && (sel_q == 2'b10);
        bus.O_SPMV_sel       = spmv_q;
        bus.O_mode_sel       = mode_q;
        bus.O_fc_relu_en     = relu_q;
        bus.O_busy           = (state_q != S_IDLE) && (state_q != S_ERR);
        bus.O_task_done      = (state_q == S_DONE);
        bus.O_layer_cnt      = layer_cnt_q;
        bus.O_err            = (state_q == S_ERR);
        bus.O_err_code       = err_code_q;
    end
endmodule
